mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between instruction fetch (IF) and data access (DM) requesters.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_arb_select.sv | 30 +++
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared FSM encodings, grant ids and helpers for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  localparam int CNT_W = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status bundle of the arbiter; slave = arbiter side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              grant_id;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           busy, grant_id
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           busy, grant_id
  );
endinterface

// File: rtl/mem_arb_select.sv
// Winner pick: data side has priority until fetch has lost STARVE_MAX times in a row.
module mem_arb_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic pick,
  output logic winner
);
  logic [CNT_W-1:0] starve_q, starve_d;

  assign winner = (dm_req && !(if_req && starve_q == CNT_W'(STARVE_MAX))) ? GNT_DM : GNT_IF;

  always_comb begin
    starve_d = starve_q;
    if (pick) begin
      if (winner == GNT_IF) starve_d = '0;
      else if (if_req)      starve_d = sat_inc(starve_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory sharer: IDLE -> ACCESS -> WAIT(MEM_LAT) -> DONE, all outputs registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        wait_q, wait_d;
  logic              gnt_q, we_q, mem_en_q, mem_we_q, busy_q;
  logic              if_ack_q, dm_ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, if_rdata_q, dm_rdata_q;
  logic              pick, winner, last_wait;

  mem_arb_select #(.STARVE_MAX(STARVE_MAX)) u_sel (
    .clk    (clk),
    .rst    (rst),
    .if_req (bus.if_req),
    .dm_req (bus.dm_req),
    .pick   (pick),
    .winner (winner)
  );

  assign last_wait = (state_q == WAIT) && (wait_q == LAT_M1);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pick    = 1'b0;
    case (state_q)
      IDLE: if (bus.if_req || bus.dm_req) begin
        pick    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        state_d = WAIT;
        wait_d  = '0;
      end
      WAIT: if (last_wait) state_d = DONE;
            else           wait_d  = wait_q + 3'd1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      gnt_q      <= GNT_IF;
      we_q       <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      busy_q   <= (state_d != IDLE);
      mem_en_q <= pick;
      mem_we_q <= pick && (winner == GNT_DM) && bus.dm_we;
      if_ack_q <= (state_d == DONE) && (gnt_q == GNT_IF);
      dm_ack_q <= (state_d == DONE) && (gnt_q == GNT_DM);
      // Request inputs are sampled only here; later changes are ignored.
      if (pick) begin
        gnt_q <= winner;
        if (winner == GNT_DM) begin
          addr_q  <= bus.dm_addr;
          wdata_q <= bus.dm_wdata;
          we_q    <= bus.dm_we;
        end else begin
          addr_q  <= bus.if_addr;
          wdata_q <= '0;
          we_q    <= 1'b0;
        end
      end
      if (last_wait) begin
        if (gnt_q == GNT_IF) if_rdata_q <= bus.mem_rdata;
        else if (!we_q)      dm_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = gnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: DUT a (MEM_LAT=1) and DUT b (MEM_LAT=3), each with a latency-accurate memory model.
module tb_mem_port_arbiter;
  logic clk, rst;
  int   errors = 0;
  int   checks = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  // Memory returns valid data only MEM_LAT cycles after mem_en, junk otherwise.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [7:0]  pipe_a = '0, pipe_b = '0;

  always @(posedge clk) begin
    pipe_a <= {pipe_a[6:0], bus_a.mem_en};
    pipe_b <= {pipe_b[6:0], bus_b.mem_en};
    if (bus_a.mem_en && bus_a.mem_we) mem_a[bus_a.mem_addr[9:2]] <= bus_a.mem_wdata;
    if (bus_b.mem_en && bus_b.mem_we) mem_b[bus_b.mem_addr[9:2]] <= bus_b.mem_wdata;
  end

  assign bus_a.mem_rdata = pipe_a[0] ? mem_a[bus_a.mem_addr[9:2]] : 32'hBAD0BAD0;
  assign bus_b.mem_rdata = pipe_b[2] ? mem_b[bus_b.mem_addr[9:2]] : 32'hBAD0BAD0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[8'h10] = 32'h00500093;
    mem_a[8'h40] = 32'h11111111;
    mem_b[8'h40] = 32'h12345678;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic saw_ack;
    rst = 1'b0;
    repeat (3) step();
    checks++; if ({bus_a.if_ack, bus_a.dm_ack, bus_a.mem_en, bus_a.mem_we, bus_a.busy, bus_a.grant_id} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl_a: got %b want 000000", {bus_a.if_ack, bus_a.dm_ack, bus_a.mem_en, bus_a.mem_we, bus_a.busy, bus_a.grant_id});
    end
    checks++; if ({bus_a.mem_addr, bus_a.mem_wdata, bus_a.if_rdata, bus_a.dm_rdata} !== 128'h0) begin
      errors++; $display("FAIL reset_data_a: got %h want 0", {bus_a.mem_addr, bus_a.mem_wdata, bus_a.if_rdata, bus_a.dm_rdata});
    end
    checks++; if ({bus_b.busy, bus_b.mem_en, bus_b.dm_ack} !== 3'b0) begin
      errors++; $display("FAIL reset_ctrl_b: got %b want 000", {bus_b.busy, bus_b.mem_en, bus_b.dm_ack});
    end
    rst = 1'b1;
    step();
    // fetch, then reset while in WAIT (cycle t=2)
    bus_a.if_req = 1'b1; bus_a.if_addr = 32'h80;
    step(); step();
    checks++; if (bus_a.busy !== 1'b1) begin
      errors++; $display("FAIL reset_pre_busy: got %b want 1", bus_a.busy);
    end
    rst = 1'b0;
    #1;
    checks++; if ({bus_a.busy, bus_a.mem_en, bus_a.if_ack, bus_a.grant_id, bus_a.mem_addr} !== 36'h0) begin
      errors++; $display("FAIL reset_midwait: got %h want 0", {bus_a.busy, bus_a.mem_en, bus_a.if_ack, bus_a.grant_id, bus_a.mem_addr});
    end
    bus_a.if_req = 1'b0;
    saw_ack = 1'b0;
    repeat (4) begin
      step();
      if (bus_a.if_ack || bus_a.busy) saw_ack = 1'b1;
    end
    checks++; if (saw_ack !== 1'b0) begin
      errors++; $display("FAIL reset_no_ack: got %b want 0", saw_ack);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    bus_a.if_req = 1'b1; bus_a.if_addr = 32'h40;
    step();  // t=1
    checks++; if ({bus_a.mem_en, bus_a.mem_we, bus_a.busy, bus_a.grant_id} !== 4'b1010) begin
      errors++; $display("FAIL fetch_t1_ctrl: got %b want 1010", {bus_a.mem_en, bus_a.mem_we, bus_a.busy, bus_a.grant_id});
    end
    checks++; if (bus_a.mem_addr !== 32'h40) begin
      errors++; $display("FAIL fetch_t1_addr: got %h want 00000040", bus_a.mem_addr);
    end
    step();  // t=2
    checks++; if ({bus_a.mem_en, bus_a.if_ack} !== 2'b00) begin
      errors++; $display("FAIL fetch_t2: got %b want 00", {bus_a.mem_en, bus_a.if_ack});
    end
    step();  // t=3
    checks++; if ({bus_a.if_ack, bus_a.dm_ack} !== 2'b10) begin
      errors++; $display("FAIL fetch_t3_ack: got %b want 10", {bus_a.if_ack, bus_a.dm_ack});
    end
    checks++; if (bus_a.if_rdata !== 32'h00500093) begin
      errors++; $display("FAIL fetch_t3_rdata: got %h want 00500093", bus_a.if_rdata);
    end
    bus_a.if_req = 1'b0;
    step();  // t=4
    checks++; if ({bus_a.if_ack, bus_a.busy} !== 2'b00) begin
      errors++; $display("FAIL fetch_t4: got %b want 00", {bus_a.if_ack, bus_a.busy});
    end
  endtask

  task automatic test_dm_write();
    bus_a.dm_req = 1'b1; bus_a.dm_we = 1'b1;
    bus_a.dm_addr = 32'h100; bus_a.dm_wdata = 32'hDEADBEEF;
    step();  // t=1
    checks++; if ({bus_a.mem_en, bus_a.mem_we, bus_a.grant_id} !== 3'b111) begin
      errors++; $display("FAIL wr_t1_ctrl: got %b want 111", {bus_a.mem_en, bus_a.mem_we, bus_a.grant_id});
    end
    checks++; if ({bus_a.mem_addr, bus_a.mem_wdata} !== {32'h100, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wr_t1_bus: got %h want 00000100deadbeef", {bus_a.mem_addr, bus_a.mem_wdata});
    end
    step();  // t=2
    checks++; if ({bus_a.mem_en, bus_a.dm_ack} !== 2'b00) begin
      errors++; $display("FAIL wr_t2: got %b want 00", {bus_a.mem_en, bus_a.dm_ack});
    end
    step();  // t=3
    checks++; if ({bus_a.dm_ack, bus_a.if_ack} !== 2'b10) begin
      errors++; $display("FAIL wr_t3_ack: got %b want 10", {bus_a.dm_ack, bus_a.if_ack});
    end
    checks++; if (bus_a.dm_rdata !== 32'h0) begin
      errors++; $display("FAIL wr_rdata_kept: got %h want 00000000", bus_a.dm_rdata);
    end
    bus_a.dm_req = 1'b0; bus_a.dm_we = 1'b0;
    step();
  endtask

  task automatic test_protocol();
    bus_a.dm_req = 1'b1; bus_a.dm_we = 1'b0; bus_a.dm_addr = 32'h100;
    step();  // t=1
    checks++; if ({bus_a.mem_en, bus_a.mem_addr} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL proto_t1: got %h want 100000100", {bus_a.mem_en, bus_a.mem_addr});
    end
    step();  // t=2: requester misbehaves
    bus_a.dm_addr = 32'h200; bus_a.dm_req = 1'b0;
    step();  // t=3
    checks++; if ({bus_a.dm_ack, bus_a.mem_addr} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL proto_t3_ack: got %h want 100000100", {bus_a.dm_ack, bus_a.mem_addr});
    end
    checks++; if (bus_a.dm_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL proto_rdata: got %h want deadbeef", bus_a.dm_rdata);
    end
    step(); step();
    checks++; if ({bus_a.dm_ack, bus_a.busy, bus_a.mem_en} !== 3'b000) begin
      errors++; $display("FAIL proto_idle: got %b want 000", {bus_a.dm_ack, bus_a.busy, bus_a.mem_en});
    end
  endtask

  task automatic contention_round(input int r, input logic last);
    logic       got [5];
    int         n;
    logic       done, overlap;
    bus_a.if_req = 1'b1; bus_a.if_addr = 32'h40;
    bus_a.dm_req = 1'b1; bus_a.dm_we = 1'b0; bus_a.dm_addr = 32'h100;
    n = 0; done = 1'b0; overlap = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      step();
      if (bus_a.if_ack && bus_a.dm_ack) overlap = 1'b1;
      if (bus_a.mem_en) begin
        if (n < 5) got[n] = bus_a.grant_id;
        n++;
      end
      if (bus_a.if_ack) begin
        done = 1'b1;
        bus_a.if_req = 1'b0;
        if (last) bus_a.dm_req = 1'b0;
      end
    end
    checks++; if (done !== 1'b1 || n !== 5) begin
      errors++; $display("FAIL contend%0d_grants: got done=%b grants=%0d want done=1 grants=5", r, done, n);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (got[k] !== (k < 4 ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL contend%0d_grant%0d: got %b want %b", r, k, got[k], (k < 4 ? 1'b1 : 1'b0));
        end
      end
    end
    checks++; if (bus_a.if_rdata !== 32'h00500093) begin
      errors++; $display("FAIL contend%0d_if_rdata: got %h want 00500093", r, bus_a.if_rdata);
    end
    checks++; if (overlap !== 1'b0) begin
      errors++; $display("FAIL contend%0d_ack_overlap: got %b want 0", r, overlap);
    end
  endtask

  task automatic test_contention();
    contention_round(1, 1'b0);
    step();
    // second round shows the counter restarted from 0 after the IF grant
    contention_round(2, 1'b1);
    repeat (6) step();
    checks++; if (bus_a.busy !== 1'b0) begin
      errors++; $display("FAIL contend_drain: got busy=%b want 0", bus_a.busy);
    end
  endtask

  task automatic test_latency3();
    bus_b.dm_req = 1'b1; bus_b.dm_we = 1'b0; bus_b.dm_addr = 32'h100;
    step();  // t=1
    checks++; if ({bus_b.mem_en, bus_b.busy, bus_b.grant_id} !== 3'b111) begin
      errors++; $display("FAIL lat3_t1: got %b want 111", {bus_b.mem_en, bus_b.busy, bus_b.grant_id});
    end
    for (int t = 2; t <= 4; t++) begin
      step();
      checks++; if ({bus_b.mem_en, bus_b.busy, bus_b.dm_ack} !== 3'b010) begin
        errors++; $display("FAIL lat3_t%0d: got %b want 010", t, {bus_b.mem_en, bus_b.busy, bus_b.dm_ack});
      end
    end
    checks++; if (bus_b.dm_rdata !== 32'h0) begin
      errors++; $display("FAIL lat3_t4_rdata: got %h want 00000000", bus_b.dm_rdata);
    end
    step();  // t=5
    checks++; if ({bus_b.dm_ack, bus_b.busy} !== 2'b11) begin
      errors++; $display("FAIL lat3_t5_ack: got %b want 11", {bus_b.dm_ack, bus_b.busy});
    end
    checks++; if (bus_b.dm_rdata !== 32'h12345678) begin
      errors++; $display("FAIL lat3_t5_rdata: got %h want 12345678", bus_b.dm_rdata);
    end
    bus_b.dm_req = 1'b0;
    step();  // t=6
    checks++; if ({bus_b.dm_ack, bus_b.busy} !== 2'b00) begin
      errors++; $display("FAIL lat3_t6: got %b want 00", {bus_b.dm_ack, bus_b.busy});
    end
  endtask

  initial begin
    rst = 1'b0;
    bus_a.if_req = 1'b0; bus_a.if_addr = '0;
    bus_a.dm_req = 1'b0; bus_a.dm_we = 1'b0; bus_a.dm_addr = '0; bus_a.dm_wdata = '0;
    bus_b.if_req = 1'b0; bus_b.if_addr = '0;
    bus_b.dm_req = 1'b0; bus_b.dm_we = 1'b0; bus_b.dm_addr = '0; bus_b.dm_wdata = '0;
    test_reset();
    test_single_fetch();
    test_dm_write();
    test_protocol();
    test_contention();
    test_latency3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
